// File: rtl/priority_encoder.sv
// priority_encoder
//   Highest-index-wins priority encoder with a registered copy of the result.
//
//   Parameters
//     WIDTH   number of request inputs (2..256)
//     OW      index width, $clog2(WIDTH)
//
//   Ports
//     clk      in   1      rising-edge clock for out_q / valid_q
//     rst_n    in   1      synchronous active-low reset of out_q / valid_q
//     en       in   1      load enable for out_q / valid_q
//     in       in   WIDTH  request vector, bit i set = request i active
//     out      out  OW     index of highest set bit (combinational), 0 when idle
//     valid    out  1      any request active (combinational)
//     onehot   out  WIDTH  one-hot mask of the winning bit (combinational)
//     out_q    out  OW     registered out
//     valid_q  out  1      registered valid
module priority_encoder #(
  parameter int WIDTH = 8,
  localparam int OW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] in,
  output logic [OW-1:0]    out,
  output logic             valid,
  output logic [WIDTH-1:0] onehot,
  output logic [OW-1:0]    out_q,
  output logic             valid_q
);

  logic [OW-1:0]    w_idx;
  logic             w_valid;
  logic [WIDTH-1:0] w_onehot;
  logic [OW-1:0]    r_out_q;
  logic             r_valid_q;

  // Ascending scan: later (higher) set bits overwrite earlier ones, so the
  // highest set index wins. Only real bit positions are ever encoded, so
  // codes above WIDTH-1 cannot appear for non-power-of-two widths.
  always_comb begin
    w_idx    = '0;
    w_valid  = 1'b0;
    w_onehot = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (in[i]) begin
        w_idx    = OW'(i);
        w_valid  = 1'b1;
        w_onehot = WIDTH'(1) << i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_q   <= '0;
      r_valid_q <= 1'b0;
    end else if (en) begin
      r_out_q   <= w_idx;
      r_valid_q <= w_valid;
    end
  end

  assign out     = w_idx;
  assign valid   = w_valid;
  assign onehot  = w_onehot;
  assign out_q   = r_out_q;
  assign valid_q = r_valid_q;

endmodule

// File: tb/tb_priority_encoder.sv
module tb_priority_encoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [7:0] tb_in = '0;
  logic [2:0] out8, out_q8;
  logic       valid8, valid_q8;
  logic [7:0] onehot8;

  logic [4:0] tb_in5 = '0;
  logic [2:0] out5, out_q5;
  logic       valid5, valid_q5;
  logic [4:0] onehot5;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  priority_encoder #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .en(en), .in(tb_in),
    .out(out8), .valid(valid8), .onehot(onehot8),
    .out_q(out_q8), .valid_q(valid_q8)
  );

  priority_encoder #(.WIDTH(5)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .en(en), .in(tb_in5),
    .out(out5), .valid(valid5), .onehot(onehot5),
    .out_q(out_q5), .valid_q(valid_q5)
  );

  // Reference: index of highest set bit = floor(log2(v)), -1 for v == 0.
  function automatic int ref_msb(input int unsigned v);
    int idx = -1;
    int unsigned t = v;
    while (t != 0) begin
      t = t / 2;
      idx++;
    end
    return idx;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0] vin;
    int         exp_out;
    logic       exp_valid;
    logic [7:0] exp_oh;
  } vec_t;

  vec_t tbl[$];

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int      m;
    int      exp_q;
    logic    exp_vq;
    logic [7:0] oh_exp;

    tbl.push_back('{8'h00, 0, 1'b0, 8'h00});
    for (int k = 0; k < 8; k++) tbl.push_back('{8'(1 << k), k, 1'b1, 8'(1 << k)});
    tbl.push_back('{8'b0000_1100, 3, 1'b1, 8'b0000_1000});
    tbl.push_back('{8'b0011_0100, 5, 1'b1, 8'b0010_0000});
    tbl.push_back('{8'hFF,        7, 1'b1, 8'h80});

    // Combinational outputs work while reset is held.
    foreach (tbl[i]) begin
      tb_in = tbl[i].vin;
      #1;
      chk("tbl_out",    32'(out8),    32'(tbl[i].exp_out));
      chk("tbl_valid",  32'(valid8),  32'(tbl[i].exp_valid));
      chk("tbl_onehot", 32'(onehot8), 32'(tbl[i].exp_oh));
    end

    // Reset for two edges.
    rst_n = 1'b0; en = 1'b1; tb_in = 8'hA5;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_q",   32'(out_q8),   0);
    chk("rst_valid_q", 32'(valid_q8), 0);

    // Load then hold.
    rst_n = 1'b1; en = 1'b1; tb_in = 8'h30;
    #1;
    chk("pre_edge_out_q", 32'(out_q8), 0);
    @(posedge clk); @(negedge clk);
    chk("load_out_q",   32'(out_q8),   5);
    chk("load_valid_q", 32'(valid_q8), 1);
    en = 1'b0; tb_in = 8'h01;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("hold_out_q",   32'(out_q8),   5);
    chk("hold_valid_q", 32'(valid_q8), 1);
    chk("hold_comb_out", 32'(out8),    0);

    // Reset overrides enable.
    en = 1'b1; tb_in = 8'h80; rst_n = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("ovr_out_q",   32'(out_q8),   0);
    chk("ovr_valid_q", 32'(valid_q8), 0);
    chk("ovr_out",     32'(out8),     7);
    chk("ovr_valid",   32'(valid8),   1);

    // Resume on first enabled edge after reset release.
    rst_n = 1'b1; en = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("resume_hold_q", 32'(out_q8), 0);
    en = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("resume_out_q",   32'(out_q8),   7);
    chk("resume_valid_q", 32'(valid_q8), 1);

    // Idle input loads valid_q = 0.
    tb_in = 8'h00;
    @(posedge clk); @(negedge clk);
    chk("idle_valid_q", 32'(valid_q8), 0);
    chk("idle_out_q",   32'(out_q8),   0);

    // Exhaustive WIDTH = 8.
    for (int v = 0; v < 256; v++) begin
      tb_in = 8'(v);
      #1;
      m = ref_msb(v);
      oh_exp = (m < 0) ? 8'h00 : 8'(1 << m);
      chk("ex8_out",    32'(out8),    (m < 0) ? 0 : m);
      chk("ex8_valid",  32'(valid8),  (m < 0) ? 0 : 1);
      chk("ex8_onehot", 32'(onehot8), 32'(oh_exp));
    end

    // Exhaustive WIDTH = 5 (non-power-of-two).
    tb_in5 = 5'b10000;
    #1;
    chk("w5_top_out",   32'(out5),   4);
    chk("w5_top_valid", 32'(valid5), 1);
    for (int v = 0; v < 32; v++) begin
      tb_in5 = 5'(v);
      #1;
      m = ref_msb(v);
      chk("ex5_out",    32'(out5),    (m < 0) ? 0 : m);
      chk("ex5_valid",  32'(valid5),  (m < 0) ? 0 : 1);
      chk("ex5_onehot", 32'(onehot5), (m < 0) ? 0 : (1 << m));
      chk("ex5_range",  32'(out5 > 3'd4), 0);
    end

    // Random registered-path traffic against a register model.
    @(negedge clk);
    rst_n = 1'b0; en = 1'b0;
    @(posedge clk); @(negedge clk);
    exp_q = 0; exp_vq = 1'b0;
    for (int n = 0; n < 400; n++) begin
      tb_in  = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) tb_in = 8'($urandom_range(0, 1)) << $urandom_range(0, 7);
      en     = 1'($urandom_range(0, 1));
      rst_n  = ($urandom_range(0, 15) != 0);
      #1;
      m = ref_msb(32'(tb_in));
      chk("rnd_out", 32'(out8), (m < 0) ? 0 : m);
      @(posedge clk);
      if (!rst_n) begin
        exp_q = 0; exp_vq = 1'b0;
      end else if (en) begin
        exp_q = (m < 0) ? 0 : m;
        exp_vq = (m >= 0);
      end
      @(negedge clk);
      chk("rnd_out_q",   32'(out_q8),   32'(exp_q));
      chk("rnd_valid_q", 32'(valid_q8), 32'(exp_vq));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
